// File: rtl/fb_update_sched.sv
// -----------------------------------------------------------------------------
// fb_update_sched
//
// Owns the single port of the RGB888 frame buffer. Two users share it: the TFT
// pixel read path and a bar-graph renderer that draws the HR and SpO2 bars.
// Active-video reads always win the port. Writes go out only while the TFT is
// in blanking, one pixel per cycle, and the write sequencer holds its place
// whenever video is active.
//
// After reset the whole buffer is cleared to BG_COLOR. After that, each ALU
// data strobe causes one redraw: the HR region and then the SpO2 region.
// Every pixel in both regions is rewritten, so a bar that got shorter is
// erased.
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_hr           heart rate in bpm, unsigned
//   i_spo2         SpO2 in %, unsigned
//   i_ALU_DV       one-cycle strobe; i_hr and i_spo2 are valid
//   i_row_pixel    TFT current row
//   i_col_pixel    TFT current column
//   i_blank        1 = TFT in blanking, so the RAM port is free for writes
//   o_fb_addr      RAM address (registered)
//   o_fb_we        RAM write enable (registered)
//   o_fb_wdata     RAM write data (registered)
//   o_busy         1 whenever a clear or a redraw is in progress
//   o_frame_done   one-cycle pulse when a bar redraw completes
// -----------------------------------------------------------------------------
module fb_update_sched #(
    parameter int          H_ACTIVE   = 800,
    parameter int          V_ACTIVE   = 480,
    parameter int          ADDR_W     = 19,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter logic [23:0] HR_COLOR   = 24'hFF0000,
    parameter logic [23:0] SPO2_COLOR = 24'h0000FF,
    parameter int          BAR_COL0   = 100,
    parameter int          HR_ROW0    = 100,
    parameter int          SPO2_ROW0  = 300,
    parameter int          BAR_H      = 40,
    parameter int          HR_SCALE   = 2,
    parameter int          SPO2_SCALE = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_hr,
    input  logic [7:0]        i_spo2,
    input  logic              i_ALU_DV,
    input  logic [15:0]       i_row_pixel,
    input  logic [15:0]       i_col_pixel,
    input  logic              i_blank,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic              o_fb_we,
    output logic [23:0]       o_fb_wdata,
    output logic              o_busy,
    output logic              o_frame_done
);

    typedef enum logic [1:0] {
        ST_INIT_CLEAR,
        ST_IDLE,
        ST_DRAW_HR,
        ST_DRAW_SPO2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] HR_START   = ADDR_W'(HR_ROW0 * H_ACTIVE + BAR_COL0);
    localparam logic [ADDR_W-1:0] SPO2_START = ADDR_W'(SPO2_ROW0 * H_ACTIVE + BAR_COL0);
    // From the last column of one row to BAR_COL0 of the next row.
    localparam logic [ADDR_W-1:0] ROW_SKIP   = ADDR_W'(BAR_COL0 + 1);
    localparam logic [15:0]       BAR_MAX    = 16'(H_ACTIVE - BAR_COL0);
    localparam logic [15:0]       COL_FIRST  = 16'(BAR_COL0);
    localparam logic [15:0]       COL_LAST   = 16'(H_ACTIVE - 1);
    localparam logic [15:0]       ROW_LAST   = 16'(BAR_H - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       col_q;       // absolute column inside a bar region
    logic [15:0]       row_q;       // row offset inside a bar region
    logic              pend_valid_q;
    logic [7:0]        pend_hr_q, pend_spo2_q;
    logic [7:0]        act_hr_q, act_spo2_q;

    logic [15:0]       hr_raw, spo2_raw, len_hr, len_spo2, col_off;
    logic [ADDR_W-1:0] rd_addr;
    logic              row_end, issue, last_write, load_pass, done_d;
    logic [23:0]       pix_color;

    // Bar lengths. They are clamped so that a bar never runs past the last
    // column of the screen.
    assign hr_raw   = 16'(act_hr_q) * 16'(HR_SCALE);
    assign spo2_raw = 16'(act_spo2_q) * 16'(SPO2_SCALE);
    assign len_hr   = (hr_raw > BAR_MAX) ? BAR_MAX : hr_raw;
    assign len_spo2 = (spo2_raw > BAR_MAX) ? BAR_MAX : spo2_raw;
    assign col_off  = col_q - COL_FIRST;
    assign row_end  = (col_q == COL_LAST);
    assign rd_addr  = ADDR_W'(i_row_pixel) * ADDR_W'(H_ACTIVE) + ADDR_W'(i_col_pixel);
    assign o_busy   = (state_q != ST_IDLE);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        last_write = 1'b0;
        load_pass  = 1'b0;
        done_d     = 1'b0;
        pix_color  = BG_COLOR;
        case (state_q)
            ST_INIT_CLEAR: begin
                issue      = i_blank;
                last_write = (wr_addr_q == LAST_PIXEL);
                if (issue && last_write) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (pend_valid_q) begin
                    load_pass = 1'b1;
                    state_d   = ST_DRAW_HR;
                end
            end
            ST_DRAW_HR: begin
                issue      = i_blank;
                last_write = row_end && (row_q == ROW_LAST);
                if (col_off < len_hr) pix_color = HR_COLOR;
                if (issue && last_write) state_d = ST_DRAW_SPO2;
            end
            ST_DRAW_SPO2: begin
                issue      = i_blank;
                last_write = row_end && (row_q == ROW_LAST);
                if (col_off < len_spo2) pix_color = SPO2_COLOR;
                if (issue && last_write) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from the values they held before the clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_INIT_CLEAR;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_addr_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_hr_q    <= '0;
            pend_spo2_q  <= '0;
            act_hr_q     <= '0;
            act_spo2_q   <= '0;
            o_fb_addr    <= '0;
            o_fb_we      <= 1'b0;
            o_fb_wdata   <= '0;
            o_frame_done <= 1'b0;
        end else begin
            // Capture the ALU data. A later strobe overwrites the values. A
            // strobe in the same cycle as the IDLE hand-off keeps pending set.
            if (i_ALU_DV) begin
                pend_hr_q    <= i_hr;
                pend_spo2_q  <= i_spo2;
                pend_valid_q <= 1'b1;
            end else if (load_pass) begin
                pend_valid_q <= 1'b0;
            end

            // Write sequencer. It advances only when a write is actually
            // issued, so active video stalls it in place.
            if (load_pass) begin
                act_hr_q   <= pend_hr_q;
                act_spo2_q <= pend_spo2_q;
                wr_addr_q  <= HR_START;
                col_q      <= COL_FIRST;
                row_q      <= '0;
            end else if (issue) begin
                if (last_write) begin
                    // Only the HR->SpO2 hand-off needs this. After a clear or
                    // a SpO2 pass, IDLE reloads the counters before they are used.
                    wr_addr_q <= SPO2_START;
                    col_q     <= COL_FIRST;
                    row_q     <= '0;
                end else if (state_q == ST_INIT_CLEAR || !row_end) begin
                    wr_addr_q <= wr_addr_q + 1'b1;
                    col_q     <= col_q + 1'b1;
                end else begin
                    wr_addr_q <= wr_addr_q + ROW_SKIP;
                    col_q     <= COL_FIRST;
                    row_q     <= row_q + 1'b1;
                end
            end

            // Port mux. Address, data and write enable for a scheduled write
            // all appear together one cycle later. Otherwise the port follows
            // the TFT read address.
            if (issue) begin
                o_fb_addr  <= wr_addr_q;
                o_fb_we    <= 1'b1;
                o_fb_wdata <= pix_color;
            end else begin
                o_fb_addr  <= rd_addr;
                o_fb_we    <= 1'b0;
            end
            o_frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_fb_update_sched.sv
// -----------------------------------------------------------------------------
// tb_fb_update_sched
//
// Scoreboard bench for fb_update_sched. It uses a reduced screen geometry so
// that several full clears and redraws fit in a short run. Each expected write
// is queued at the moment its cause is driven: reset release for a clear, a
// DV strobe for a redraw. A monitor on the falling edge pops the queue for
// every write the DUT issues and compares address and data.
// -----------------------------------------------------------------------------
module tb_fb_update_sched;

    localparam int          TB_H      = 200;
    localparam int          TB_V      = 40;
    localparam int          TB_AW     = 19;
    localparam int          TB_COL0   = 20;
    localparam int          TB_HR0    = 5;
    localparam int          TB_SP0    = 20;
    localparam int          TB_BAR_H  = 4;
    localparam int          TB_HR_SC  = 2;
    localparam int          TB_SP_SC  = 5;
    localparam logic [23:0] C_BG      = 24'h000000;
    localparam logic [23:0] C_HR      = 24'hFF0000;
    localparam logic [23:0] C_SP      = 24'h0000FF;
    localparam int          REGION    = TB_BAR_H * (TB_H - TB_COL0);

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [7:0]        i_hr, i_spo2;
    logic              i_ALU_DV;
    logic [15:0]       i_row_pixel, i_col_pixel;
    logic              i_blank;
    logic [TB_AW-1:0]  o_fb_addr;
    logic              o_fb_we;
    logic [23:0]       o_fb_wdata;
    logic              o_busy;
    logic              o_frame_done;

    fb_update_sched #(
        .H_ACTIVE  (TB_H),
        .V_ACTIVE  (TB_V),
        .ADDR_W    (TB_AW),
        .BG_COLOR  (C_BG),
        .HR_COLOR  (C_HR),
        .SPO2_COLOR(C_SP),
        .BAR_COL0  (TB_COL0),
        .HR_ROW0   (TB_HR0),
        .SPO2_ROW0 (TB_SP0),
        .BAR_H     (TB_BAR_H),
        .HR_SCALE  (TB_HR_SC),
        .SPO2_SCALE(TB_SP_SC)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_hr        (i_hr),
        .i_spo2      (i_spo2),
        .i_ALU_DV    (i_ALU_DV),
        .i_row_pixel (i_row_pixel),
        .i_col_pixel (i_col_pixel),
        .i_blank     (i_blank),
        .o_fb_addr   (o_fb_addr),
        .o_fb_we     (o_fb_we),
        .o_fb_wdata  (o_fb_wdata),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [TB_AW-1:0] addr;
        logic [23:0]      data;
        bit               last;   // final write of a redraw pass
    } wr_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  pops = 0;
    int  fd_cnt = 0;
    bit  last_end = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_clear();
        wr_t e;
        for (int a = 0; a < TB_H * TB_V; a++) begin
            e.addr = TB_AW'(a);
            e.data = C_BG;
            e.last = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic push_region(input int row0, input logic [23:0] color, input int len, input bit fin);
        wr_t e;
        for (int r = 0; r < TB_BAR_H; r++) begin
            for (int c = TB_COL0; c < TB_H; c++) begin
                e.addr = TB_AW'((row0 + r) * TB_H + c);
                e.data = ((c - TB_COL0) < len) ? color : C_BG;
                e.last = fin && (r == TB_BAR_H - 1) && (c == TB_H - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic push_pass(input int hr, input int spo2);
        int lh, ls;
        lh = hr * TB_HR_SC;
        ls = spo2 * TB_SP_SC;
        if (lh > TB_H - TB_COL0) lh = TB_H - TB_COL0;
        if (ls > TB_H - TB_COL0) ls = TB_H - TB_COL0;
        push_region(TB_HR0, C_HR, lh, 1'b0);
        push_region(TB_SP0, C_SP, ls, 1'b1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_fb_we) begin
                check("write_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check("write_addr_data", {o_fb_addr, o_fb_wdata}, {e.addr, e.data});
                    last_end = e.last;
                    pops++;
                end
            end
            if (o_frame_done) begin
                fd_cnt++;
                check("frame_done_after_last_write", 64'(last_end), 64'd1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_dv(input logic [7:0] hr, input logic [7:0] spo2);
        @(posedge i_clk); #1;
        i_hr     = hr;
        i_spo2   = spo2;
        i_ALU_DV = 1'b1;
        @(posedge i_clk); #1;
        i_ALU_DV = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while ((o_busy || sb.size() != 0) && n < max_cyc) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n < max_cyc), 64'd1);
    endtask

    task automatic wait_pops(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (pops < target && n < max_cyc) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n < max_cyc), 64'd1);
    endtask

    int p0, p_stall;

    initial begin
        i_rst_n     = 1'b0;
        i_blank     = 1'b1;
        i_hr        = '0;
        i_spo2      = '0;
        i_ALU_DV    = 1'b0;
        i_row_pixel = '0;
        i_col_pixel = '0;

        // Reset state
        #3;
        check("rst_we",    64'(o_fb_we),      64'd0);
        check("rst_addr",  64'(o_fb_addr),    64'd0);
        check("rst_wdata", 64'(o_fb_wdata),   64'd0);
        check("rst_fd",    64'(o_frame_done), 64'd0);
        check("rst_busy",  64'(o_busy),       64'd1);

        // Initial clear
        push_clear();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        wait_done(20000, "clear");
        check("clear_busy_low",      64'(o_busy), 64'd0);
        check("clear_no_frame_done", 64'(fd_cnt), 64'd0);

        // Single redraw
        drive_dv(8'd60, 8'd30);
        push_pass(60, 30);
        repeat (3) @(negedge i_clk);
        check("pass_busy_high", 64'(o_busy), 64'd1);
        wait_done(5000, "pass1");
        check("pass1_frames", 64'(fd_cnt), 64'd1);

        // Several strobes during DRAW_HR: the last one wins for the next pass
        p0 = pops;
        drive_dv(8'd64, 8'd30);
        push_pass(64, 30);
        wait_pops(p0 + 50, 2000, "multi_pre");
        drive_dv(8'd72, 8'd10);
        drive_dv(8'd80, 8'd20);
        push_pass(80, 20);
        wait_done(10000, "multi");
        check("multi_frames", 64'(fd_cnt), 64'd3);

        // Active-video stall in the middle of a draw
        p0 = pops;
        drive_dv(8'd45, 8'd12);
        push_pass(45, 12);
        wait_pops(p0 + 40, 2000, "stall_pre");
        @(posedge i_clk); #1;
        i_blank     = 1'b0;
        i_row_pixel = 16'd10;
        i_col_pixel = 16'd20;
        @(posedge i_clk);
        @(negedge i_clk);
        p_stall = pops;
        check("stall_we",   64'(o_fb_we),   64'd0);
        check("stall_addr", 64'(o_fb_addr), 64'(10 * TB_H + 20));
        i_row_pixel = 16'd3;
        i_col_pixel = 16'd7;
        @(posedge i_clk);
        @(negedge i_clk);
        check("stall_addr_track", 64'(o_fb_addr), 64'(3 * TB_H + 7));
        repeat (4) @(negedge i_clk);
        check("stall_frozen", 64'(pops), 64'(p_stall));
        check("stall_busy",   64'(o_busy), 64'd1);
        @(posedge i_clk); #1;
        i_blank     = 1'b1;
        i_row_pixel = '0;
        i_col_pixel = '0;
        wait_done(5000, "stall");
        check("stall_frames", 64'(fd_cnt), 64'd4);

        // Clamp and zero length
        drive_dv(8'd0, 8'd255);
        push_pass(0, 255);
        wait_done(5000, "clamp");
        check("clamp_frames", 64'(fd_cnt), 64'd5);

        // Reset in the middle of DRAW_SPO2, with a strobe already pending
        p0 = pops;
        drive_dv(8'd50, 8'd25);
        push_pass(50, 25);
        wait_pops(p0 + REGION + 100, 3000, "rst_pre");
        drive_dv(8'd90, 8'd90);
        @(posedge i_clk); #3;
        i_rst_n = 1'b0;
        #1;
        check("midrst_we",    64'(o_fb_we),      64'd0);
        check("midrst_addr",  64'(o_fb_addr),    64'd0);
        check("midrst_wdata", 64'(o_fb_wdata),   64'd0);
        check("midrst_fd",    64'(o_frame_done), 64'd0);
        check("midrst_busy",  64'(o_busy),       64'd1);
        sb.delete();
        push_clear();
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        // A strobe during the clear is serviced after the clear finishes
        wait_pops(pops + 200, 2000, "reclear_pre");
        drive_dv(8'd33, 8'd7);
        push_pass(33, 7);
        wait_done(20000, "reclear");
        check("reclear_frames", 64'(fd_cnt), 64'd6);
        repeat (50) @(negedge i_clk);
        check("pending_dropped_busy", 64'(o_busy), 64'd0);
        check("pending_dropped_sb",   64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
